// File: rtl/leaf_pkg.sv
// Shared project package: FSM state encoding and parameter range limits
// for the edge-event transmitter.
package leaf_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } tx_state_e;

  localparam int unsigned HOLD_CYCLES_MIN = 2;
  localparam int unsigned HOLD_CYCLES_MAX = 65535;
  localparam int unsigned MAX_PENDING_MIN = 1;
  localparam int unsigned MAX_PENDING_MAX = 255;

endpackage

// File: rtl/event_hold_timer.sv
// Down-counting hold timer: loads a value, counts down to zero and
// stops there, flagging zero so the FSM knows the level may change.
module event_hold_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments and an async
  // active-low reset in the sensitivity list.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/edge_event_tx.sv
// Encodes accepted events as level toggles on o_line, holding each level
// at least HOLD_CYCLES clocks so a synchronizer + debouncer sees it intact.
module edge_event_tx
  import leaf_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic                               i_flush,
  input  logic                               i_clear_ovf,
  output logic                               o_line,
  output logic                               o_busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   o_pending,
  output logic                               o_overflow
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX    = PEND_W'(MAX_PENDING);

  if (HOLD_CYCLES < HOLD_CYCLES_MIN || HOLD_CYCLES > HOLD_CYCLES_MAX) begin : g_bad_hold
    $error("edge_event_tx: HOLD_CYCLES out of range 2..65535");
  end
  if (MAX_PENDING < MAX_PENDING_MIN || MAX_PENDING > MAX_PENDING_MAX) begin : g_bad_pend
    $error("edge_event_tx: MAX_PENDING out of range 1..255");
  end

  tx_state_e        state;
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_next;
  logic             accept;
  logic             dispatch;
  logic             hold_zero;

  // Ready comes from the registered count only: a dispatch in the same
  // edge does not free a slot early.
  assign o_ready  = (pending < PEND_MAX);
  assign accept   = i_valid && o_ready;
  assign dispatch = (pending != '0) && ((state == ST_IDLE) || hold_zero);

  event_hold_timer #(
    .WIDTH(HOLD_W)
  ) u_hold_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .load     (dispatch),
    .value    (HOLD_RELOAD),
    .zero     (hold_zero)
  );

  // Flush keeps only an event accepted in the same edge.
  always_comb begin
    pending_next = pending;
    if (i_flush) begin
      pending_next = PEND_W'(accept);
    end else if (accept && !dispatch) begin
      pending_next = pending + PEND_W'(1);
    end else if (dispatch && !accept) begin
      pending_next = pending - PEND_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      pending    <= '0;
      o_line     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      pending <= pending_next;

      if (dispatch) begin
        state  <= ST_HOLD;
        o_line <= ~o_line;
      end else if (state == ST_HOLD && hold_zero) begin
        state <= ST_IDLE;
      end

      if (i_valid && !o_ready) begin
        o_overflow <= 1'b1;
      end else if (i_clear_ovf) begin
        o_overflow <= 1'b0;
      end
    end
  end

  assign o_busy    = (state == ST_HOLD) || (pending != '0);
  assign o_pending = pending;

endmodule

// File: tb/tb_edge_event_tx.sv
// Self-checking bench for edge_event_tx: directed scenarios plus random
// traffic compared against a timing-rule model of the toggle line.
module tb_edge_event_tx;

  localparam int HOLD = 8;
  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid = 1'b0;
  logic       flush = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       line, ready, busy, overflow;
  logic [2:0] pending;

  edge_event_tx #(
    .HOLD_CYCLES(HOLD),
    .MAX_PENDING(MAXP)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_flush    (flush),
    .i_clear_ovf(clear_ovf),
    .o_line     (line),
    .o_busy     (busy),
    .o_pending  (pending),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int edge_n     = 0;

  // Model: a level may change at edge n when something is queued and at
  // least HOLD edges have passed since the previous change.
  int m_pend;
  bit m_line;
  bit m_ovf;
  int m_last;
  int m_accepted;
  int m_flushed;

  bit prev_line;
  int dut_toggles[$];

  task automatic model_reset();
    m_pend     = 0;
    m_line     = 1'b0;
    m_ovf      = 1'b0;
    m_last     = -100000;
    m_accepted = 0;
    m_flushed  = 0;
  endtask

  task automatic model_edge(input bit v, input bit f, input bit c);
    bit rdy;
    bit acc;
    bit disp;
    rdy  = (m_pend < MAXP);
    acc  = v && rdy;
    disp = (m_pend > 0) && (edge_n - m_last >= HOLD);
    if (disp) begin
      m_line = !m_line;
      m_last = edge_n;
    end
    if (v && !rdy)  m_ovf = 1'b1;
    else if (c)     m_ovf = 1'b0;
    if (acc) m_accepted++;
    if (f) begin
      m_flushed += m_pend - int'(disp);
      m_pend = int'(acc);
    end else begin
      m_pend = m_pend + int'(acc) - int'(disp);
    end
  endtask

  function automatic logic [6:0] model_vec();
    bit m_busy;
    m_busy = (m_pend != 0) || (edge_n - m_last < HOLD);
    return {m_line, 1'(m_pend < MAXP), m_busy, m_ovf, 3'(m_pend)};
  endfunction

  // One rising edge; inputs were set beforehand, outputs settle by return.
  task automatic step();
    bit v, f, c;
    v = valid;
    f = flush;
    c = clear_ovf;
    @(posedge clk);
    edge_n++;
    model_edge(v, f, c);
    #1;
    if (line !== prev_line) dut_toggles.push_back(edge_n);
    prev_line = line;
  endtask

  task automatic do_reset();
    valid     = 1'b0;
    flush     = 1'b0;
    clear_ovf = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    edge_n    = 0;
    prev_line = 1'b0;
    dut_toggles.delete();
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({line, ready, busy, overflow, pending} !== 7'b0_1_0_0_000) begin
      mismatched++;
      $display("FAIL reset_state: got line/rdy/busy/ovf/pend=%b want %b",
               {line, ready, busy, overflow, pending}, 7'b0_1_0_0_000);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(); step();
    valid = 1'b1;
    step();
    valid = 1'b0;
    compared++;
    if (line !== 1'b0 || pending !== 3'd1) begin
      mismatched++;
      $display("FAIL single_accept: got line=%b pend=%0d want line=0 pend=1", line, pending);
    end
    for (int e = 4; e <= 14; e++) begin
      step();
      compared++;
      if (line !== 1'b1 || busy !== (e < 12) || pending !== 3'd0) begin
        mismatched++;
        $display("FAIL single_hold_e%0d: got line=%b busy=%b pend=%0d want line=1 busy=%b pend=0",
                 e, line, busy, pending, (e < 12));
      end
    end
  endtask

  task automatic test_burst();
    int exp_t[5] = '{4, 12, 20, 28, 36};
    do_reset();
    step(); step();
    valid = 1'b1;
    repeat (5) step();
    valid = 1'b0;
    compared++;
    if (ready !== 1'b0 || pending !== 3'd4) begin
      mismatched++;
      $display("FAIL burst_full: got ready=%b pend=%0d want ready=0 pend=4", ready, pending);
    end
    while (edge_n < 45) step();
    compared++;
    if (dut_toggles.size() != 5) begin
      mismatched++;
      $display("FAIL burst_count: got %0d toggles want 5", dut_toggles.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (dut_toggles[i] != exp_t[i]) begin
          mismatched++;
          $display("FAIL burst_edge%0d: got edge %0d want %0d", i, dut_toggles[i], exp_t[i]);
        end
      end
    end
    compared++;
    if (line !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL burst_final: got line=%b busy=%b want line=1 busy=0", line, busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(); step();
    valid = 1'b1;
    repeat (6) step();
    compared++;
    if (overflow !== 1'b1 || pending !== 3'd4) begin
      mismatched++;
      $display("FAIL ovf_set: got ovf=%b pend=%0d want ovf=1 pend=4", overflow, pending);
    end
    clear_ovf = 1'b1;
    step();
    compared++;
    if (overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_set_wins: got ovf=%b want 1", overflow);
    end
    valid = 1'b0;
    step();
    clear_ovf = 1'b0;
    compared++;
    if (overflow !== 1'b0 || pending !== 3'd4) begin
      mismatched++;
      $display("FAIL ovf_clear: got ovf=%b pend=%0d want ovf=0 pend=4", overflow, pending);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(); step();
    valid = 1'b1;
    repeat (5) step();
    valid = 1'b0;
    while (edge_n < 13) step();
    compared++;
    if (pending !== 3'd3) begin
      mismatched++;
      $display("FAIL flush_pre: got pend=%0d want 3", pending);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    compared++;
    if (pending !== 3'd0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL flush_edge14: got pend=%0d busy=%b want pend=0 busy=1", pending, busy);
    end
    while (edge_n < 30) begin
      step();
      compared++;
      if (line !== 1'b0 || busy !== (edge_n < 20)) begin
        mismatched++;
        $display("FAIL flush_e%0d: got line=%b busy=%b want line=0 busy=%b",
                 edge_n, line, busy, (edge_n < 20));
      end
    end
    compared++;
    if (dut_toggles.size() != 2) begin
      mismatched++;
      $display("FAIL flush_toggles: got %0d want 2", dut_toggles.size());
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    step(); step();
    valid = 1'b1;
    repeat (3) step();
    valid = 1'b0;
    step(); step();
    compared++;
    if (line !== 1'b1 || pending !== 3'd2) begin
      mismatched++;
      $display("FAIL midhold_pre: got line=%b pend=%0d want line=1 pend=2", line, pending);
    end
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({line, ready, busy, pending} !== 6'b0_1_0_000) begin
      mismatched++;
      $display("FAIL midhold_async: got line/rdy/busy/pend=%b want %b",
               {line, ready, busy, pending}, 6'b0_1_0_000);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    edge_n    = 0;
    prev_line = 1'b0;
    dut_toggles.delete();
    valid = 1'b1;
    step();
    valid = 1'b0;
    compared++;
    if (line !== 1'b0 || pending !== 3'd1) begin
      mismatched++;
      $display("FAIL midhold_accept: got line=%b pend=%0d want line=0 pend=1", line, pending);
    end
    step();
    compared++;
    if (line !== 1'b1) begin
      mismatched++;
      $display("FAIL midhold_toggle: got line=%b want 1", line);
    end
  endtask

  task automatic test_random();
    int min_gap;
    do_reset();
    for (int i = 0; i < 10060; i++) begin
      if (i < 10000) begin
        valid     = ($urandom_range(0, 99) < 45);
        flush     = ($urandom_range(0, 99) < 2);
        clear_ovf = ($urandom_range(0, 99) < 3);
      end else begin
        valid     = 1'b0;
        flush     = 1'b0;
        clear_ovf = 1'b0;
      end
      step();
      compared++;
      if ({line, ready, busy, overflow, pending} !== model_vec()) begin
        mismatched++;
        $display("FAIL rand_e%0d: got line/rdy/busy/ovf/pend=%b want %b",
                 edge_n, {line, ready, busy, overflow, pending}, model_vec());
      end
    end
    compared++;
    if (dut_toggles.size() != m_accepted - m_flushed) begin
      mismatched++;
      $display("FAIL rand_toggle_count: got %0d want %0d (accepted %0d flushed %0d)",
               dut_toggles.size(), m_accepted - m_flushed, m_accepted, m_flushed);
    end
    min_gap = 1 << 30;
    for (int i = 1; i < dut_toggles.size(); i++)
      if (dut_toggles[i] - dut_toggles[i-1] < min_gap) min_gap = dut_toggles[i] - dut_toggles[i-1];
    compared++;
    if (dut_toggles.size() > 1 && min_gap < HOLD) begin
      mismatched++;
      $display("FAIL rand_min_spacing: got %0d clocks want >= %0d", min_gap, HOLD);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_flush();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/edge_event_tx.md
EDGE_EVENT_TX -- requirements
Module: edge_event_tx

Purpose: encode discrete events as level toggles on one output line. Each level is held long enough to pass a downstream 2-flop synchronizer and shift-register debouncer intact.

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, minimum clocks each o_line level is held; legal range 2..65535.
REQ-002 Parameter MAX_PENDING, default 4, depth of the event backlog counter; legal range 1..255.
REQ-003 i_clk  input  1  clock.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  event request; accepted when i_valid && o_ready at a rising i_clk edge.
REQ-006 o_ready  output  1  backlog not full.
REQ-007 i_flush  input  1  synchronous discard of queued, undispatched events.
REQ-008 i_clear_ovf  input  1  synchronous clear of o_overflow.
REQ-009 o_line  output  1  encoded toggle line to the remote receiver.
REQ-010 o_busy  output  1  hold in progress or backlog non-zero.
REQ-011 o_pending  output  $clog2(MAX_PENDING+1)  queued event count.
REQ-012 o_overflow  output  1  sticky: an event was offered while o_ready was low.

Function
REQ-013 o_line SHALL be a registered output with no combinational path from any input.
REQ-014 o_ready SHALL equal (pending < MAX_PENDING), decoded from the registered count only; there is no same-cycle dispatch credit.
REQ-015 Pending count update per edge:
- accept only: +1
- dispatch only: -1
- accept and dispatch in the same edge: unchanged
REQ-016 FSM states are IDLE and HOLD; the hold counter width is $clog2(HOLD_CYCLES).
REQ-017 IDLE with pending>0: at the next edge, toggle o_line, load the hold counter with HOLD_CYCLES-1, dispatch one event, and go to HOLD.
REQ-018 IDLE with pending==0: remain IDLE; o_line is unchanged.
REQ-019 HOLD with counter>0: decrement the counter; o_line is unchanged.
REQ-020 HOLD with counter==0 and pending>0: at that edge, toggle o_line, reload HOLD_CYCLES-1, dispatch, and stay in HOLD. Toggle spacing under backlog is exactly HOLD_CYCLES clocks.
REQ-021 HOLD with counter==0 and pending==0: go to IDLE; o_line is unchanged.
REQ-022 Latency: an event accepted at edge k toggles o_line at edge k+1 if the FSM is IDLE at edge k.
REQ-023 i_flush SHALL set the pending count to 0 at the next edge, or to 1 if an accept occurs in the same edge. It does not abort the current HOLD, and o_line never toggles because of a flush.
REQ-024 o_overflow SHALL set on i_valid && !o_ready and clear on i_clear_ovf; set wins if both occur. A refused event is dropped.
REQ-025 o_busy SHALL equal (state==HOLD) || (pending!=0).
REQ-026 The HOLD_CYCLES and MAX_PENDING parameter ranges SHALL be checked by elaboration-time assertions.

Reset
REQ-027 Asynchronous reset SHALL force state=IDLE, hold counter=0, pending=0, o_line=0, o_overflow=0. The resulting outputs are o_ready=1, o_busy=0, o_pending=0.
REQ-028 Reset mid-HOLD SHALL drive o_line to 0 immediately and lose all queued events. A downstream receiver may therefore see one falling edge; this is accepted.

Structure
REQ-029 The state enum typedef (IDLE, HOLD) SHALL live in the shared project package leaf_pkg, together with the parameter range limits.
REQ-030 The hold timer SHALL be one sub-module, event_hold_timer, with load/value/zero-flag ports. The pending counter and FSM stay inline.

Verification (HOLD_CYCLES=8, MAX_PENDING=4)
REQ-031 Reset, then a single-cycle i_valid at edge 3 -> o_line 0->1 at edge 4 and held to edge 12; o_busy falls at edge 12; o_pending returns to 0.
REQ-032 i_valid high for edges 3-7 -> all five accepted; o_ready low after edge 7; o_line toggles at edges 4, 12, 20, 28, 36; final o_line=1.
REQ-033 Full backlog plus i_valid at edge 8 -> event dropped and o_overflow=1; i_clear_ovf together with a refused i_valid -> o_overflow stays 1; i_clear_ovf alone -> 0.
REQ-034 i_flush at edge 14 with pending=3 -> o_pending=0 at edge 14; no toggle after the current hold; FSM returns to IDLE at edge 20.
REQ-035 Reset asserted mid-HOLD with o_line=1 and pending=2 -> o_line=0, o_pending=0, o_busy=0 immediately; the first event after release toggles to 1 one edge after acceptance.
REQ-036 Random valid/flush traffic over 10k cycles -> toggle count equals accepted minus flushed events; no two toggles closer than 8 clocks.
